// File: rtl/normal_op_pkg.sv
// Shared types and default sizing for the normal-operation loader:
// bank decode of the CPU address and the loader FSM states.
package normal_op_pkg;

  localparam int DEFAULT_WIDTH     = 13;
  localparam int DEFAULT_TRANS_NUM = 249;
  localparam int RAM_DEPTH         = 256;

  typedef enum logic [1:0] {
    BANK_CYCLE = 2'b00,
    BANK_DUTY  = 2'b01,
    BANK_PHASE = 2'b10
  } bank_e;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    COPY,
    DRAIN
  } state_e;

endpackage

// File: rtl/shadow_ram.sv
// Simple dual-port shadow RAM: one write port, one registered read port,
// read-first on a same-address collision.
module shadow_ram #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/normal_op_loader.sv
// Loads CPU-written cycle/duty/phase shadow RAMs into registered output
// arrays once per UPDATE frame. Optional macro DUTY_CLAMP_EN limits duty to cycle/2.
module normal_op_loader
  import normal_op_pkg::*;
#(
  parameter int               WIDTH         = DEFAULT_WIDTH,
  parameter int               TRANS_NUM     = DEFAULT_TRANS_NUM,
  parameter logic [WIDTH-1:0] DEFAULT_CYCLE = 13'd5000
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic                              CPU_WE,
  input  logic [9:0]                        CPU_ADDR,
  input  logic [15:0]                       CPU_DATA,
  input  logic                              UPDATE,
  input  logic                              OVERRUN_CLR,
  output logic [0:TRANS_NUM-1][WIDTH-1:0]   CYCLE,
  output logic [0:TRANS_NUM-1][WIDTH-1:0]   DUTY,
  output logic [0:TRANS_NUM-1][WIDTH-1:0]   PHASE,
  output logic                              OUT_VALID,
  output logic                              BUSY,
  output logic                              OVERRUN
);

  localparam logic [7:0] LAST_IDX  = 8'(TRANS_NUM - 1);
  localparam logic [8:0] IDX_LIMIT = 9'(TRANS_NUM);

  state_e           state, state_nx;
  logic [7:0]       idx, idx_nx;
  logic             init_we, rd_issue;
  logic             rd_valid;
  logic [7:0]       rd_idx;
  logic             cpu_ok;
  logic             cyc_we, duty_we, phase_we;
  logic [7:0]       ram_waddr;
  logic [WIDTH-1:0] cpu_word;
  logic [WIDTH-1:0] cyc_wdata, duty_wdata, phase_wdata;
  logic [WIDTH-1:0] cyc_rd, duty_rd, phase_rd;
  logic [WIDTH-1:0] duty_eff;

  // INIT blocks the CPU so the default fill never races a real write.
  assign cpu_ok = CPU_WE && (state != INIT) && ({1'b0, CPU_ADDR[7:0]} < IDX_LIMIT)
                  && (CPU_ADDR[9:8] != 2'b11);
  assign cpu_word = CPU_DATA[WIDTH-1:0];

  generate
    if (WIDTH < 16) begin : g_data_unused
      logic unused_data_bits;
      assign unused_data_bits = ^CPU_DATA[15:WIDTH];
    end
  endgenerate

  assign cyc_we      = init_we || (cpu_ok && (CPU_ADDR[9:8] == BANK_CYCLE));
  assign duty_we     = init_we || (cpu_ok && (CPU_ADDR[9:8] == BANK_DUTY));
  assign phase_we    = init_we || (cpu_ok && (CPU_ADDR[9:8] == BANK_PHASE));
  assign ram_waddr   = init_we ? idx : CPU_ADDR[7:0];
  assign cyc_wdata   = init_we ? DEFAULT_CYCLE : cpu_word;
  assign duty_wdata  = init_we ? '0 : cpu_word;
  assign phase_wdata = init_we ? '0 : cpu_word;

  shadow_ram #(.WIDTH(WIDTH), .DEPTH(RAM_DEPTH)) u_cycle_ram (
    .clk(CLK), .we(cyc_we), .waddr(ram_waddr), .wdata(cyc_wdata),
    .raddr(idx), .rdata(cyc_rd)
  );

  shadow_ram #(.WIDTH(WIDTH), .DEPTH(RAM_DEPTH)) u_duty_ram (
    .clk(CLK), .we(duty_we), .waddr(ram_waddr), .wdata(duty_wdata),
    .raddr(idx), .rdata(duty_rd)
  );

  shadow_ram #(.WIDTH(WIDTH), .DEPTH(RAM_DEPTH)) u_phase_ram (
    .clk(CLK), .we(phase_we), .waddr(ram_waddr), .wdata(phase_wdata),
    .raddr(idx), .rdata(phase_rd)
  );

`ifdef DUTY_CLAMP_EN
  logic [WIDTH-1:0] duty_limit;
  assign duty_limit = cyc_rd >> 1;
  assign duty_eff   = (duty_rd > duty_limit) ? duty_limit : duty_rd;
`else
  assign duty_eff = duty_rd;
`endif

  // One shared index walks the RAMs for both the default fill and the copy.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    init_we  = 1'b0;
    rd_issue = 1'b0;
    case (state)
      INIT: begin
        init_we = 1'b1;
        if (idx == LAST_IDX) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 8'd1;
        end
      end
      IDLE: begin
        if (UPDATE) begin
          state_nx = COPY;
          idx_nx   = '0;
        end
      end
      COPY: begin
        rd_issue = 1'b1;
        if (idx == LAST_IDX) begin
          state_nx = DRAIN;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 8'd1;
        end
      end
      DRAIN: state_nx = IDLE;
      default: state_nx = INIT;
    endcase
  end

  assign BUSY = (state == INIT);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= INIT;
      idx       <= '0;
      rd_valid  <= 1'b0;
      rd_idx    <= '0;
      OUT_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      rd_valid  <= rd_issue;
      rd_idx    <= idx;
      OUT_VALID <= (state == DRAIN);
      if (UPDATE && ((state == COPY) || (state == DRAIN))) begin
        OVERRUN <= 1'b1;
      end else if (OVERRUN_CLR) begin
        OVERRUN <= 1'b0;
      end
    end
  end

  // Output arrays change only from RAM read data, one element per cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CYCLE <= {TRANS_NUM{DEFAULT_CYCLE}};
      DUTY  <= '0;
      PHASE <= '0;
    end else if (rd_valid) begin
      CYCLE[rd_idx] <= cyc_rd;
      DUTY[rd_idx]  <= duty_eff;
      PHASE[rd_idx] <= phase_rd;
    end
  end

endmodule

// File: tb/tb_normal_op_loader.sv
// Directed bench for normal_op_loader: expected frames are queued at UPDATE
// time and checked by a monitor whenever OUT_VALID pulses.
module tb_normal_op_loader;
  import normal_op_pkg::*;

  localparam int WIDTH     = 13;
  localparam int TRANS_NUM = 249;
  localparam int LAT       = TRANS_NUM + 2;
  localparam logic [WIDTH-1:0] DEF_CYC = 13'd5000;

  typedef logic [0:TRANS_NUM-1][WIDTH-1:0] arr_t;
  typedef struct {
    arr_t cyc;
    arr_t duty;
    arr_t phase;
    int   due;
  } frame_t;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       CPU_WE = 1'b0;
  logic [9:0] CPU_ADDR = '0;
  logic [15:0] CPU_DATA = '0;
  logic       UPDATE = 1'b0;
  logic       OVERRUN_CLR = 1'b0;
  arr_t       CYCLE, DUTY, PHASE;
  logic       OUT_VALID, BUSY, OVERRUN;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  frame_t sb_q[$];
  arr_t   m_cyc, m_duty, m_phase, def_cyc_arr, zero_arr;

  normal_op_loader #(.WIDTH(WIDTH), .TRANS_NUM(TRANS_NUM), .DEFAULT_CYCLE(DEF_CYC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR),
    .CPU_DATA(CPU_DATA), .UPDATE(UPDATE), .OVERRUN_CLR(OVERRUN_CLR),
    .CYCLE(CYCLE), .DUTY(DUTY), .PHASE(PHASE),
    .OUT_VALID(OUT_VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] exp_duty(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
`ifdef DUTY_CLAMP_EN
    return (d > (c >> 1)) ? (c >> 1) : d;
`else
    return d;
`endif
  endfunction

  function automatic frame_t model_frame(input int due);
    frame_t f;
    f.cyc   = m_cyc;
    f.phase = m_phase;
    for (int i = 0; i < TRANS_NUM; i++) f.duty[i] = exp_duty(m_cyc[i], m_duty[i]);
    f.due = due;
    return f;
  endfunction

  task automatic check_output(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic compare_arr(input string name, input arr_t got, input arr_t want);
    int first;
    checks++;
    if (got !== want) begin
      errors++;
      first = 0;
      for (int i = TRANS_NUM - 1; i >= 0; i--) if (got[i] !== want[i]) first = i;
      $display("[TB] FAIL %s: element %0d got %0d, expected %0d", name, first, got[first], want[first]);
    end
  endtask

  // Scoreboard monitor: every OUT_VALID pulse must match the oldest queued frame.
  always @(negedge CLK) begin : monitor
    frame_t f;
    if (RESET_N && OUT_VALID) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected OUT_VALID at cycle %0d, expected none", cyc);
      end else begin
        f = sb_q.pop_front();
        check_output("frame OUT_VALID cycle", cyc, f.due);
        compare_arr("frame CYCLE", CYCLE, f.cyc);
        compare_arr("frame DUTY", DUTY, f.duty);
        compare_arr("frame PHASE", PHASE, f.phase);
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DATA = '0; UPDATE = 1'b0; OVERRUN_CLR = 1'b0;
  endtask

  task automatic apply_stimulus(input logic we, input logic [9:0] addr, input logic [15:0] data,
                                input logic upd, input logic clr);
    CPU_WE = we; CPU_ADDR = addr; CPU_DATA = data; UPDATE = upd; OVERRUN_CLR = clr;
  endtask

  task automatic cpu_write(input logic [1:0] bank, input int index, input int data);
    tick();
    apply_stimulus(1'b1, {bank, 8'(index)}, 16'(data), 1'b0, 1'b0);
  endtask

  task automatic tick_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic issue_update(output int k);
    tick();
    k = cyc;
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic wait_valid();
    for (int n = 0; n < LAT + 20; n++) begin
      tick();
      if (OUT_VALID) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL OUT_VALID timeout at cycle %0d, expected a pulse", cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Releases reset and counts BUSY cycles; the writes inside INIT must be dropped.
  task automatic release_and_init();
    int busy_cnt;
    tick();
    RESET_N = 1'b1;
    busy_cnt = 0;
    while (BUSY && busy_cnt < 400) begin
      busy_cnt++;
      tick();
      if (busy_cnt == 5) apply_stimulus(1'b1, {BANK_CYCLE, 8'd0}, 16'd111, 1'b0, 1'b0);
      if (busy_cnt == 6) apply_stimulus(1'b1, {BANK_DUTY, 8'd0}, 16'd222, 1'b0, 1'b0);
      if (busy_cnt == 7) apply_stimulus(1'b1, {BANK_PHASE, 8'd1}, 16'd333, 1'b0, 1'b0);
    end
    check_output("BUSY cycles after reset", busy_cnt, TRANS_NUM);
  endtask

  task automatic model_defaults();
    m_cyc = def_cyc_arr;
    m_duty = zero_arr;
    m_phase = zero_arr;
  endtask

  initial begin : stimulus
    int k, k2;
    frame_t f;
    for (int i = 0; i < TRANS_NUM; i++) begin
      def_cyc_arr[i] = DEF_CYC;
      zero_arr[i] = '0;
    end
    model_defaults();

    #2 RESET_N = 1'b0;
    idle(2);
    check_output("reset BUSY", BUSY, 1);
    check_output("reset OUT_VALID", OUT_VALID, 0);
    check_output("reset OVERRUN", OVERRUN, 0);
    compare_arr("reset CYCLE", CYCLE, def_cyc_arr);
    compare_arr("reset DUTY", DUTY, zero_arr);
    compare_arr("reset PHASE", PHASE, zero_arr);
    release_and_init();

    $display("[TB] dropped writes and first frame");
    cpu_write(2'b00, 249, 999);
    cpu_write(2'b11, 5, 777);
    cpu_write(2'b01, 255, 555);
    issue_update(k);
    sb_q.push_back(model_frame(k + LAT));
    wait_valid();

    $display("[TB] index 5 update and element timing");
    cpu_write(BANK_DUTY, 5, 2500);
    cpu_write(BANK_PHASE, 5, 1234);
    cpu_write(BANK_CYCLE, 5, 4000);
    m_duty[5] = 13'd2500; m_phase[5] = 13'd1234; m_cyc[5] = 13'd4000;
    issue_update(k);
    sb_q.push_back(model_frame(k + LAT));
    tick_until(k + 7);
    check_output("DUTY[5] before its copy", DUTY[5], 0);
    check_output("CYCLE[5] before its copy", CYCLE[5], 5000);
    tick();
    check_output("DUTY[5] at its copy", DUTY[5], exp_duty(13'd4000, 13'd2500));
    check_output("CYCLE[5] at its copy", CYCLE[5], 4000);
    check_output("PHASE[5] at its copy", PHASE[5], 1234);
    wait_valid();

    $display("[TB] writes racing the copy");
    issue_update(k);
    f = model_frame(k + LAT);
    f.duty[200] = exp_duty(m_cyc[200], 13'd77);
    f.duty[150] = exp_duty(m_cyc[150], 13'd66);
    sb_q.push_back(f);
    tick_until(k + 10);
    apply_stimulus(1'b1, {BANK_DUTY, 8'd3}, 16'd88, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, {BANK_DUTY, 8'd200}, 16'd77, 1'b0, 1'b0);
    tick_until(k + 101);
    apply_stimulus(1'b1, {BANK_DUTY, 8'd100}, 16'd55, 1'b0, 1'b0);
    tick_until(k + 150);
    apply_stimulus(1'b1, {BANK_DUTY, 8'd150}, 16'd66, 1'b0, 1'b0);
    wait_valid();
    m_duty[3] = 13'd88; m_duty[200] = 13'd77; m_duty[100] = 13'd55; m_duty[150] = 13'd66;
    issue_update(k);
    sb_q.push_back(model_frame(k + LAT));
    wait_valid();

    $display("[TB] overrun during copy");
    check_output("OVERRUN before copy", OVERRUN, 0);
    issue_update(k);
    sb_q.push_back(model_frame(k + LAT));
    tick_until(k + 100);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    tick_until(k + 102);
    check_output("OVERRUN after UPDATE in COPY", OVERRUN, 1);
    wait_valid();
    idle(20);
    check_output("OVERRUN sticky", OVERRUN, 1);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    check_output("OVERRUN after clear", OVERRUN, 0);

    $display("[TB] overrun in DRAIN with simultaneous clear");
    issue_update(k);
    sb_q.push_back(model_frame(k + LAT));
    tick_until(k + 250);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1);
    tick();
    check_output("OVERRUN set beats clear", OVERRUN, 1);
    check_output("OUT_VALID after DRAIN", OUT_VALID, 1);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    check_output("OVERRUN cleared again", OVERRUN, 0);
    idle(20);

    $display("[TB] back-to-back frames");
    issue_update(k);
    sb_q.push_back(model_frame(k + LAT));
    wait_valid();
    k2 = cyc;
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    sb_q.push_back(model_frame(k2 + LAT));
    wait_valid();
    check_output("OVERRUN after back-to-back", OVERRUN, 0);

    $display("[TB] duty clamp");
    cpu_write(BANK_CYCLE, 0, 4000);
    cpu_write(BANK_DUTY, 0, 3000);
    m_cyc[0] = 13'd4000; m_duty[0] = 13'd3000;
    issue_update(k);
    sb_q.push_back(model_frame(k + LAT));
    wait_valid();
`ifdef DUTY_CLAMP_EN
    check_output("DUTY[0] clamped", DUTY[0], 2000);
`else
    check_output("DUTY[0] unclamped", DUTY[0], 3000);
`endif

    $display("[TB] reset in the middle of a copy");
    issue_update(k);
    tick_until(k + 50);
    RESET_N = 1'b0;
    #1;
    compare_arr("mid-copy reset CYCLE", CYCLE, def_cyc_arr);
    compare_arr("mid-copy reset DUTY", DUTY, zero_arr);
    compare_arr("mid-copy reset PHASE", PHASE, zero_arr);
    check_output("mid-copy reset BUSY", BUSY, 1);
    check_output("mid-copy reset OUT_VALID", OUT_VALID, 0);
    model_defaults();
    idle(3);
    release_and_init();
    issue_update(k);
    sb_q.push_back(model_frame(k + LAT));
    wait_valid();
    idle(5);

    check_output("frames left in scoreboard", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
